// File: rtl/usb_tx_scheduler.sv
// Launch sequencer for the USB transmitter: latches handshake/data requests,
// issues one launch strobe at a time, then waits for EOP and an idle gap.
module usb_tx_scheduler #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int LEN_W          = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hs_req,
  input  logic             hs_good,
  input  logic             data_req,
  input  logic [LEN_W-1:0] data_len,
  input  logic [LEN_W-1:0] fifo_count,
  input  logic             tx_done,
  input  logic             err_clr,
  output logic             tx_transmit,
  output logic             tx_send_good,
  output logic             tx_send_bad,
  output logic             hs_ack,
  output logic             data_ack,
  output logic             busy,
  output logic             timeout_err
);

  // Request protocol: a req pulse is latched as pending; the matching ack
  // pulse is emitted in the same cycle as its launch strobe, which also
  // retires the pending entry. There is no back-pressure on the req side.

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             hs_pend, hs_good_q;
  logic             data_pend;
  logic [LEN_W-1:0] data_len_q;
  logic             launch_hs, launch_data, timeout_hit;

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    launch_hs   = 1'b0;
    launch_data = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        // Handshakes always go first; data waits until the FIFO holds the packet.
        if (hs_pend) begin
          launch_hs = 1'b1;
          state_d   = WAIT_DONE;
          cnt_d     = '0;
        end else if (data_pend && (fifo_count >= data_len_q)) begin
          launch_data = 1'b1;
          state_d     = WAIT_DONE;
          cnt_d       = '0;
        end
      end
      WAIT_DONE: begin
        // tx_done on the terminal count wins over the timeout.
        if (tx_done) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else if (cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = GAP;
          cnt_d       = GAP_LOAD;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) state_d = IDLE;
        else           cnt_d   = cnt - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      hs_pend      <= 1'b0;
      hs_good_q    <= 1'b0;
      data_pend    <= 1'b0;
      data_len_q   <= '0;
      tx_transmit  <= 1'b0;
      tx_send_good <= 1'b0;
      tx_send_bad  <= 1'b0;
      hs_ack       <= 1'b0;
      data_ack     <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      tx_send_good <= launch_hs & hs_good_q;
      tx_send_bad  <= launch_hs & ~hs_good_q;
      hs_ack       <= launch_hs;
      tx_transmit  <= launch_data;
      data_ack     <= launch_data;
      busy         <= (state_d != IDLE);

      // A fresh handshake request is never lost, even in its launch cycle.
      if (hs_req) begin
        hs_pend   <= 1'b1;
        hs_good_q <= hs_good;
      end else if (launch_hs) begin
        hs_pend <= 1'b0;
      end

      if (data_req && !data_pend) begin
        data_pend  <= 1'b1;
        data_len_q <= data_len;
      end else if (launch_data) begin
        data_pend <= 1'b0;
      end

      if (timeout_hit)  timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed, table-driven bench for usb_tx_scheduler (TIMEOUT_CYCLES=32, GAP_CYCLES=16).
module tb_usb_tx_scheduler;

  localparam int GAP = 16;
  localparam int TO  = 32;
  localparam int LW  = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          hs_req = 1'b0, hs_good = 1'b0, data_req = 1'b0;
  logic [LW-1:0] data_len = '0, fifo_count = '0;
  logic          tx_done = 1'b0, err_clr = 1'b0;
  logic          tx_transmit, tx_send_good, tx_send_bad, hs_ack, data_ack, busy, timeout_err;

  usb_tx_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .hs_req(hs_req), .hs_good(hs_good),
    .data_req(data_req), .data_len(data_len), .fifo_count(fifo_count),
    .tx_done(tx_done), .err_clr(err_clr),
    .tx_transmit(tx_transmit), .tx_send_good(tx_send_good), .tx_send_bad(tx_send_bad),
    .hs_ack(hs_ack), .data_ack(data_ack), .busy(busy), .timeout_err(timeout_err)
  );

  // Output bits: {tx_transmit, send_good, send_bad, hs_ack, data_ack, busy, timeout_err}
  wire [6:0] obs = {tx_transmit, tx_send_good, tx_send_bad, hs_ack, data_ack, busy, timeout_err};
  localparam logic [6:0] Z   = 7'b0000000;
  localparam logic [6:0] B   = 7'b0000010;
  localparam logic [6:0] E   = 7'b0000001;
  localparam logic [6:0] BE  = 7'b0000011;
  localparam logic [6:0] SG  = 7'b0101010;
  localparam logic [6:0] SB  = 7'b0011010;
  localparam logic [6:0] TX  = 7'b1000110;

  // ---------------- vector table ----------------
  // Pulse inputs apply in the first cycle of an entry only; data_len/fifo_count
  // are held. exp is checked after each of the entry's n clock edges.
  typedef struct {
    logic          hs_req, hs_good, data_req;
    logic [LW-1:0] data_len, fifo_count;
    logic          tx_done, err_clr, rst;
    int            n;
    logic [6:0]    exp;
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;

  task automatic add(input logic hr, input logic hg, input logic dr,
                     input logic [LW-1:0] dl, input logic [LW-1:0] fc,
                     input logic td, input logic ec, input logic r,
                     input int n, input logic [6:0] exp);
    vec_t v;
    v.hs_req = hr; v.hs_good = hg; v.data_req = dr;
    v.data_len = dl; v.fifo_count = fc;
    v.tx_done = td; v.err_clr = ec; v.rst = r;
    v.n = n; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic idle(input logic [LW-1:0] fc, input int n, input logic [6:0] exp);
    add(0, 0, 0, 0, fc, 0, 0, 0, n, exp);
  endtask

  // tx_done now, then the gap runs out and busy drops GAP+1 cycles later.
  task automatic finish(input logic [LW-1:0] fc);
    add(0, 0, 0, 0, fc, 1, 0, 0, 1, B);
    idle(fc, GAP - 1, B);
    idle(fc, 1, Z);
  endtask

  task automatic build_table();
    // reset, including a request presented during reset
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, Z);
    add(1, 1, 1, 0, 0, 0, 0, 1, 1, Z);
    idle(0, 3, Z);
    // ACK path: strobe at cycle 2, tx_done at cycle 20, busy low at 37
    add(1, 1, 0, 0, 0, 0, 0, 0, 1, Z);
    idle(0, 1, SG);
    idle(0, 18, B);
    finish(0);
    // priority: NAK before data, data strobe 18 cycles after tx_done
    add(1, 0, 1, 8, 8, 0, 0, 0, 1, Z);
    idle(8, 1, SB);
    add(0, 0, 0, 0, 8, 1, 0, 0, 1, B);
    idle(8, GAP - 1, B);
    idle(8, 1, Z);
    idle(8, 1, TX);
    finish(8);
    // FIFO gating: len 10 waits until fifo_count reaches 10 at cycle 50
    add(0, 0, 1, 10, 4, 0, 0, 0, 1, Z);
    idle(4, 49, Z);
    idle(10, 1, TX);
    finish(10);
    // zero-length packet launches with an empty FIFO
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, Z);
    idle(0, 1, TX);
    finish(0);
    // timeout: err 32 cycles after strobe; err_clr on that edge loses to set
    add(1, 1, 0, 0, 0, 0, 0, 0, 1, Z);
    idle(0, 1, SG);
    idle(0, TO - 1, B);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1, BE);
    idle(0, GAP - 1, BE);
    idle(0, 1, E);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1, Z);
    // tx_done on the terminal-count cycle: no error
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, Z);
    idle(0, 1, SB);
    idle(0, TO - 1, B);
    finish(0);
    // reset during WAIT_DONE with data pending: nothing launches afterwards
    add(0, 0, 1, 3, 8, 0, 0, 0, 1, Z);
    idle(8, 1, TX);
    idle(8, 3, B);
    add(0, 0, 1, 3, 8, 0, 0, 0, 1, B);
    add(0, 0, 0, 0, 8, 0, 0, 1, 1, Z);
    add(0, 0, 0, 0, 8, 1, 0, 0, 1, Z);
    idle(8, 40, Z);
    // repeated requests latched during GAP: one NAK, one data strobe
    add(1, 1, 0, 0, 0, 0, 0, 0, 1, Z);
    idle(0, 1, SG);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, B);
    add(1, 1, 0, 0, 0, 0, 0, 0, 1, B);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, B);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, B);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, B);
    idle(0, 11, B);
    idle(0, 1, Z);
    idle(0, 1, SB);
    finish(0);
    idle(0, 1, TX);
    finish(0);
    idle(0, 5, Z);
  endtask

  // ---------------- driver + scoreboard ----------------
  task automatic step_check(input int id, input int k);
    logic [6:0] want;
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL vec%0d cyc%0d got=%b want=%b", id, k, obs, want);
    end
  endtask

  task automatic drive_pulses(input logic hr, input logic hg, input logic dr,
                              input logic td, input logic ec, input logic r);
    hs_req = hr; hs_good = hg; data_req = dr;
    tx_done = td; err_clr = ec; rst = r;
  endtask

  initial begin
    build_table();
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      data_len   = vecs[i].data_len;
      fifo_count = vecs[i].fifo_count;
      for (int k = 0; k < vecs[i].n; k++) begin
        if (k == 0)
          drive_pulses(vecs[i].hs_req, vecs[i].hs_good, vecs[i].data_req,
                       vecs[i].tx_done, vecs[i].err_clr, vecs[i].rst);
        else
          drive_pulses(0, 0, 0, 0, 0, 0);
        exp_q.push_back(vecs[i].exp);
        step_check(i, k);
      end
    end
    drive_pulses(0, 0, 0, 0, 0, 0);

    // Hand-written: bounded wait for a zero-length launch, must land on cycle 2.
    begin
      int seen_at;
      seen_at = -1;
      data_len = 0; fifo_count = 0; data_req = 1'b1;
      for (int c = 1; c <= 6; c++) begin
        @(posedge clk);
        #1;
        data_req = 1'b0;
        if (tx_transmit === 1'b1 && seen_at < 0) seen_at = c;
      end
      total++;
      if (seen_at != 2) begin
        bad++;
        $display("FAIL zero_len_latency got=%0d want=2", seen_at);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_tx_scheduler.md
Name: usb_tx_scheduler

Overview:
Sequencing controller in front of the USB transmitter. It accepts handshake requests (ACK/NAK) from the receive side and data-packet requests from the SD side. It arbitrates between them and issues single-cycle launch strobes (tx_send_good / tx_send_bad / tx_transmit) to the transmitter. It then waits for end-of-packet, enforces an inter-packet idle gap, and flags transmitter timeouts.

Parameters:
GAP_CYCLES, 16, idle clock cycles enforced after each packet's tx_done before the next launch (min 1)
TIMEOUT_CYCLES, 4096, max cycles between launch strobe and tx_done before an error is declared
LEN_W, 7, width of fifo_count and data_len

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
hs_req  input  1  one-cycle handshake request from receiver
hs_good  input  1  sampled with hs_req: 1 = ACK (send good), 0 = NAK (send bad)
data_req  input  1  one-cycle data-packet request
data_len  input  LEN_W  byte count of requested data packet, sampled with data_req
fifo_count  input  LEN_W  bytes currently in the TX FIFO
tx_done  input  1  one-cycle pulse from transmitter at EOP completion
err_clr  input  1  clears timeout_err
tx_transmit  output  1  one-cycle data-packet launch strobe
tx_send_good  output  1  one-cycle ACK launch strobe
tx_send_bad  output  1  one-cycle NAK launch strobe
hs_ack  output  1  one-cycle pulse, coincident with handshake launch strobe
data_ack  output  1  one-cycle pulse, coincident with tx_transmit
busy  output  1  high whenever state != IDLE
timeout_err  output  1  sticky timeout flag

Behaviour:
- Reset: synchronous, active-high, on clk rising edge. While rst is high, all outputs are 0, pending flags and stored good/len are cleared, counter = 0, state = IDLE. Requests sampled in a reset cycle are discarded.
- Pending latches:
  - hs_req sets hs_pend and stores hs_good. A repeat hs_req while hs_pend is set overwrites the stored hs_good; it remains a single pending handshake.
  - data_req sets data_pend and stores data_len. A repeat data_req while data_pend is set is ignored.
  - Pending flags clear in the cycle their launch strobe is driven.
- States: IDLE, WAIT_DONE, GAP. All outputs are registered.
- IDLE, evaluated on registered pending flags only, so a request takes effect no earlier than the next cycle:
  - If hs_pend: next cycle drives tx_send_good = stored hs_good, tx_send_bad = !stored hs_good, and hs_ack = 1, all for exactly one cycle. State goes to WAIT_DONE and the counter is cleared.
  - Else if data_pend and fifo_count >= stored data_len: next cycle drives tx_transmit = 1 and data_ack = 1 for one cycle. State goes to WAIT_DONE and the counter is cleared. data_len = 0 (zero-length packet) launches immediately.
  - Else remain in IDLE.
  - Handshake has strict priority over data. At most one strobe is high in any cycle.
- WAIT_DONE: the counter increments each cycle.
  - tx_done → GAP, counter loaded with GAP_CYCLES-1.
  - Counter reaches TIMEOUT_CYCLES-1 without tx_done → set timeout_err, go to GAP, counter loaded with GAP_CYCLES-1.
  - tx_done in the same cycle as the timeout terminal count counts as done; no error.
- GAP: the counter decrements; at 0 → IDLE. New requests are latched in GAP but not launched. Back-to-back packets are therefore separated by ≥ GAP_CYCLES+1 cycles from tx_done to the next strobe.
- tx_done outside WAIT_DONE is ignored.
- timeout_err: set by timeout, cleared by err_clr or rst. Set wins over err_clr in the same cycle. It does not block further launches.
- Counter width: clog2(max(TIMEOUT_CYCLES, GAP_CYCLES)); no wrap is reachable.
- rst during WAIT_DONE or GAP aborts the sequence; no strobe is issued afterwards for the aborted request.

Test Plan:
- ACK path: hs_req=1, hs_good=1 at cycle 0 → tx_send_good=1 and hs_ack=1 at cycle 2 only; busy=1 from cycle 2. tx_done at cycle 20 → busy=0 at cycle 20+GAP_CYCLES+1 (cycle 37 with default 16).
- Priority: hs_req (hs_good=0) and data_req (len 8, fifo_count=8) in the same cycle → tx_send_bad first. tx_transmit follows no earlier than 17 cycles after the first tx_done.
- FIFO gating: data_req with data_len=10 and fifo_count=4 → no tx_transmit. Raise fifo_count to 10 at cycle 50 → tx_transmit at cycle 51. With data_len=0 → immediate launch.
- Timeout (TIMEOUT_CYCLES=32): launch with no tx_done → timeout_err=1 exactly 32 cycles after the strobe, then GAP, then IDLE. err_clr pulse → timeout_err=0. tx_done on the terminal-count cycle → timeout_err stays 0.
- Reset mid-operation: rst=1 for one cycle during WAIT_DONE with data_pend set → all outputs 0, IDLE. No strobe follows; a late tx_done is ignored.
- Repeat requests: two hs_req pulses (good=1, then good=0) before launch → a single tx_send_bad strobe. A second data_req while pending → one tx_transmit.
